// File: rtl/tl_a_burst_arbiter.sv
// tl_a_burst_arbiter
//   Shares one downstream TileLink A-channel port between MASTER_NUM upstream
//   requesters. Arbitration is round-robin at message granularity, and a
//   multi-beat data message stays locked to its master until the last beat.
//   The granted request passes through combinationally. Only the grant state
//   is registered.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-low reset
//   inp_valid_i/ready_o   per-master A handshake
//   inp_opcode_i          per-master opcode, 3 bits each
//   inp_size_i            per-master log2(bytes), SIZE_W bits each
//   inp_payload_i         per-master opaque bits, PAYLOAD_W each
//   oup_valid_o/ready_i   downstream A handshake
//   oup_opcode_o, oup_size_o, oup_payload_o   fields of the driven master
//   grant_idx_o           index of the master currently driven downstream
//   timeout_o             sticky stall watchdog flag
//
// Optional feature:
//   Define TL_A_ARB_WATCHDOG_EN to build the stall watchdog. When the macro
//   is not defined, timeout_o is tied to 0.

module tl_a_burst_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int BEAT_BYTES = 8,
  parameter int SIZE_W     = 4,
  parameter int PAYLOAD_W  = 128,
  parameter int TIMEOUT    = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [MASTER_NUM-1:0]           inp_valid_i,
  output logic [MASTER_NUM-1:0]           inp_ready_o,
  input  logic [MASTER_NUM*3-1:0]         inp_opcode_i,
  input  logic [MASTER_NUM*SIZE_W-1:0]    inp_size_i,
  input  logic [MASTER_NUM*PAYLOAD_W-1:0] inp_payload_i,
  output logic                            oup_valid_o,
  input  logic                            oup_ready_i,
  output logic [2:0]                      oup_opcode_o,
  output logic [SIZE_W-1:0]               oup_size_o,
  output logic [PAYLOAD_W-1:0]            oup_payload_o,
  output logic [$clog2(MASTER_NUM)-1:0]   grant_idx_o,
  output logic                            timeout_o
);

  localparam int IDX_W     = $clog2(MASTER_NUM);
  localparam int LOG_BB    = $clog2(BEAT_BYTES);
  localparam int MAX_SHIFT = (2 ** SIZE_W - 1) - LOG_BB;
  localparam int CNT_RAW   = ((MAX_SHIFT > 0) ? MAX_SHIFT : 0) + 1;
  localparam int CNT_W     = (CNT_RAW > 16) ? 16 : CNT_RAW;

  if (MASTER_NUM < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("tl_a_burst_arbiter: MASTER_NUM must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, PEND, BURST} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0]     sel;
  logic                 any_valid;
  logic [IDX_W-1:0]     drv_idx;
  logic                 drv_valid;
  logic                 ready_en;
  logic [2:0]           drv_op;
  logic [SIZE_W-1:0]    drv_size;
  logic [PAYLOAD_W-1:0] drv_payload;
  logic [CNT_W-1:0]     drv_bm1;
  logic                 hs;

  // Returns beats-1 for a message. Only data-carrying opcodes (0..3) can span
  // several beats. Messages too long for the counter saturate it.
  function automatic logic [CNT_W-1:0] beats_m1(input logic [2:0] op,
                                                input logic [SIZE_W-1:0] sz);
    int               sh;
    logic [CNT_W-1:0] one;
    one      = CNT_W'(1);
    beats_m1 = '0;
    sh       = int'(sz) - LOG_BB;
    if (op <= 3'd3 && sh > 0) begin
      if (sh >= CNT_W) beats_m1 = '1;
      else             beats_m1 = (one << sh) - one;
    end
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    next_idx = (int'(i) == MASTER_NUM - 1) ? '0 : i + 1'b1;
  endfunction

  // Round-robin pick. The scan runs from the farthest offset down to rr_q, so
  // the last hit, which is the master nearest the pointer, wins.
  always_comb begin
    sel       = rr_q;
    any_valid = 1'b0;
    for (int off = MASTER_NUM - 1; off >= 0; off--) begin
      if (inp_valid_i[(int'(rr_q) + off) % MASTER_NUM]) begin
        sel       = IDX_W'((int'(rr_q) + off) % MASTER_NUM);
        any_valid = 1'b1;
      end
    end
  end

  // Choose the master whose fields go downstream. In PEND and BURST the grant
  // is locked, so ready does not wait on valid: a mid-burst gap produces no
  // handshake anyway.
  always_comb begin
    drv_idx   = grant_q;
    drv_valid = inp_valid_i[grant_q];
    ready_en  = 1'b1;
    if (state_q == IDLE) begin
      drv_idx   = sel;
      drv_valid = any_valid;
      ready_en  = any_valid;
    end
    drv_op      = inp_opcode_i[int'(drv_idx)*3 +: 3];
    drv_size    = inp_size_i[int'(drv_idx)*SIZE_W +: SIZE_W];
    drv_payload = inp_payload_i[int'(drv_idx)*PAYLOAD_W +: PAYLOAD_W];
    drv_bm1     = beats_m1(drv_op, drv_size);
    hs          = drv_valid & oup_ready_i;
  end

  // Next-state logic. A finished message moves the pointer past its winner,
  // so that master becomes the lowest priority.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          if (!oup_ready_i) begin
            grant_d = sel;
            state_d = PEND;
          end else if (drv_bm1 == '0) begin
            rr_d = next_idx(sel);
          end else begin
            grant_d = sel;
            cnt_d   = drv_bm1;
            state_d = BURST;
          end
        end
      end
      PEND: begin
        if (hs) begin
          if (drv_bm1 == '0) begin
            rr_d    = next_idx(grant_q);
            state_d = IDLE;
          end else begin
            cnt_d   = drv_bm1;
            state_d = BURST;
          end
        end
      end
      BURST: begin
        if (hs) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            rr_d    = next_idx(grant_q);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant state register. A reset during a burst simply abandons the burst.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef TL_A_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] stall_q;
  logic            timeout_q;

  // Count consecutive locked cycles with no handshake. The flag sets on the
  // same edge that the counter reaches TIMEOUT. The counter saturates there.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else if (state_q != IDLE && !hs) begin
      if (stall_q != WD_W'(TIMEOUT)) stall_q <= stall_q + 1'b1;
      if (stall_q == WD_W'(TIMEOUT - 1)) timeout_q <= 1'b1;
    end else begin
      stall_q <= '0;
    end
  end
`endif

  // Output drive. Every output is held at zero while reset is asserted.
  always_comb begin
    oup_valid_o   = 1'b0;
    oup_opcode_o  = '0;
    oup_size_o    = '0;
    oup_payload_o = '0;
    grant_idx_o   = '0;
    inp_ready_o   = '0;
    timeout_o     = 1'b0;
    if (rst_i) begin
      oup_valid_o          = drv_valid;
      oup_opcode_o         = drv_op;
      oup_size_o           = drv_size;
      oup_payload_o        = drv_payload;
      grant_idx_o          = drv_idx;
      inp_ready_o[drv_idx] = oup_ready_i & ready_en;
`ifdef TL_A_ARB_WATCHDOG_EN
      timeout_o            = timeout_q;
`endif
    end
  end

endmodule

// File: tb/tb_tl_a_burst_arbiter.sv
// tb_tl_a_burst_arbiter
//   Drives tl_a_burst_arbiter from per-master message generators.
//   The expected outputs come from a message-level model that tracks an
//   owner, the beats left and a round-robin pointer.
//   The timeout expectation follows TL_A_ARB_WATCHDOG_EN.

module tb_tl_a_burst_arbiter;

  localparam int MN = 4;
  localparam int BB = 8;
  localparam int SW = 4;
  localparam int PW = 32;
  localparam int TO = 16;
`ifdef TL_A_ARB_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_i;
  logic [MN-1:0]    inp_valid_i;
  logic [MN-1:0]    inp_ready_o;
  logic [MN*3-1:0]  inp_opcode_i;
  logic [MN*SW-1:0] inp_size_i;
  logic [MN*PW-1:0] inp_payload_i;
  logic             oup_valid_o;
  logic             oup_ready_i;
  logic [2:0]       oup_opcode_o;
  logic [SW-1:0]    oup_size_o;
  logic [PW-1:0]    oup_payload_o;
  logic [1:0]       grant_idx_o;
  logic             timeout_o;

  always #5 clk = ~clk;

  tl_a_burst_arbiter #(
    .MASTER_NUM(MN), .BEAT_BYTES(BB), .SIZE_W(SW), .PAYLOAD_W(PW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .inp_valid_i(inp_valid_i), .inp_ready_o(inp_ready_o),
    .inp_opcode_i(inp_opcode_i), .inp_size_i(inp_size_i),
    .inp_payload_i(inp_payload_i),
    .oup_valid_o(oup_valid_o), .oup_ready_i(oup_ready_i),
    .oup_opcode_o(oup_opcode_o), .oup_size_o(oup_size_o),
    .oup_payload_o(oup_payload_o),
    .grant_idx_o(grant_idx_o), .timeout_o(timeout_o)
  );

  // Generator state per master. gen_left is the number of beats of the
  // current message still to send after its first beat.
  bit          gen_valid [MN];
  int          gen_op    [MN];
  int          gen_size  [MN];
  int          gen_left  [MN];
  logic [PW-1:0] gen_pay [MN];
  int          raise_pct;
  int          burst_pct;

  // Message-level reference model.
  int owner;
  bit started;
  int rem;
  int ptr;
  int stall;
  bit to_flag;

  int check_count = 0;
  int fail_count  = 0;
  int obs_grant;
  logic [MN-1:0] obs_ready;

  function automatic int beats(int op, int sz);
    int b;
    if (op <= 3) begin
      b = (1 << sz) / BB;
      return (b < 1) ? 1 : b;
    end
    return 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    check_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic new_msg(input int m);
    gen_op[m]   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 7);
    gen_size[m] = $urandom_range(0, 6);
    gen_pay[m]  = PW'($urandom);
  endtask

  task automatic reset_model();
    owner   = -1;
    started = 1'b0;
    rem     = 0;
    ptr     = 0;
    stall   = 0;
    to_flag = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check outputs 1 time unit later,
  // then advance the model and the generators to the state after the next edge.
  task automatic applyStimulus(input bit rst_n, input bit rdy);
    int drv;
    bit dvalid;
    bit hs;
    int n;
    logic [MN-1:0] exp_ready;
    @(negedge clk);
    rst_i       = rst_n;
    oup_ready_i = rdy;
    for (int m = 0; m < MN; m++) begin
      inp_valid_i[m]            = gen_valid[m];
      inp_opcode_i[m*3 +: 3]    = 3'(gen_op[m]);
      inp_size_i[m*SW +: SW]    = SW'(gen_size[m]);
      inp_payload_i[m*PW +: PW] = gen_pay[m];
    end
    #1;
    obs_grant = int'(grant_idx_o);
    obs_ready = inp_ready_o;
    if (!rst_n) begin
      checkOutput("rst_valid", 64'(oup_valid_o), 64'(0));
      checkOutput("rst_ready", 64'(inp_ready_o), 64'(0));
      checkOutput("rst_grant", 64'(grant_idx_o), 64'(0));
      checkOutput("rst_timeout", 64'(timeout_o), 64'(0));
      reset_model();
      for (int m = 0; m < MN; m++) gen_left[m] = 0;
    end else begin
      if (owner < 0) begin
        drv    = ptr;
        dvalid = 1'b0;
        for (int off = 0; off < MN; off++) begin
          if (!dvalid && gen_valid[(ptr + off) % MN]) begin
            drv    = (ptr + off) % MN;
            dvalid = 1'b1;
          end
        end
        exp_ready = (dvalid && rdy) ? MN'(1 << drv) : '0;
      end else begin
        drv       = owner;
        dvalid    = gen_valid[owner];
        exp_ready = rdy ? MN'(1 << drv) : '0;
      end
      hs = dvalid && rdy;
      n  = beats(gen_op[drv], gen_size[drv]);

      checkOutput("oup_valid", 64'(oup_valid_o), 64'(dvalid));
      checkOutput("inp_ready", 64'(inp_ready_o), 64'(exp_ready));
      checkOutput("timeout", 64'(timeout_o), 64'(WD_ON & to_flag));
      if (dvalid) begin
        checkOutput("grant_idx", 64'(grant_idx_o), 64'(drv));
        checkOutput("opcode", 64'(oup_opcode_o), 64'(gen_op[drv]));
        checkOutput("size", 64'(oup_size_o), 64'(gen_size[drv]));
        checkOutput("payload", 64'(oup_payload_o), 64'(gen_pay[drv]));
      end

      if (owner >= 0 && !hs) begin
        stall++;
        if (stall >= TO) to_flag = 1'b1;
      end else begin
        stall = 0;
      end

      if (owner < 0) begin
        if (dvalid) begin
          if (!hs) begin
            owner   = drv;
            started = 1'b0;
          end else if (n == 1) begin
            ptr = (drv + 1) % MN;
          end else begin
            owner   = drv;
            started = 1'b1;
            rem     = n - 1;
          end
        end
      end else if (hs) begin
        if (!started) begin
          if (n == 1) begin
            owner = -1;
            ptr   = (drv + 1) % MN;
          end else begin
            started = 1'b1;
            rem     = n - 1;
          end
        end else begin
          rem--;
          if (rem == 0) begin
            owner = -1;
            ptr   = (drv + 1) % MN;
          end
        end
      end

      if (hs) begin
        gen_valid[drv] = 1'b0;
        if (gen_left[drv] == 0) gen_left[drv] = n - 1;
        else                    gen_left[drv]--;
      end
    end

    for (int m = 0; m < MN; m++) begin
      if (!gen_valid[m]) begin
        if (gen_left[m] > 0) begin
          if (int'($urandom_range(0, 99)) < burst_pct) begin
            gen_valid[m] = 1'b1;
            gen_pay[m]   = PW'($urandom);
          end
        end else if (int'($urandom_range(0, 99)) < raise_pct) begin
          gen_valid[m] = 1'b1;
          new_msg(m);
        end
      end
    end
  endtask

  task automatic clear_gens();
    for (int m = 0; m < MN; m++) begin
      gen_valid[m] = 1'b0;
      gen_op[m]    = 4;
      gen_size[m]  = 0;
      gen_left[m]  = 0;
      gen_pay[m]   = '0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish within the time limit");
    $fatal(1, "[TB] time limit expired");
  end

  initial begin
    int exp_seq[5];
    rst_i         = 1'b0;
    oup_ready_i   = 1'b0;
    inp_valid_i   = '0;
    inp_opcode_i  = '0;
    inp_size_i    = '0;
    inp_payload_i = '0;
    raise_pct     = 0;
    burst_pct     = 100;
    clear_gens();
    reset_model();

    $display("[TB] reset and idle");
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("idle_grant_idx", 64'(obs_grant), 64'(0));
    for (int m = 0; m < MN; m++) begin
      gen_valid[m] = 1'b1;
      gen_pay[m]   = PW'(m + 1);
    end
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);

    $display("[TB] round robin with Get from every master");
    for (int i = 0; i < 8; i++) begin
      for (int m = 0; m < MN; m++) begin
        gen_valid[m] = 1'b1;
        gen_op[m]    = 4;
        gen_size[m]  = 3;
      end
      applyStimulus(1'b1, 1'b1);
      checkOutput("rr_order", 64'(obs_grant), 64'(i % MN));
    end

    $display("[TB] four-beat PutFull against a competing Get");
    clear_gens();
    applyStimulus(1'b0, 1'b1);
    gen_valid[1] = 1'b1; gen_op[1] = 0; gen_size[1] = 5; gen_pay[1] = 32'h1111;
    gen_valid[2] = 1'b1; gen_op[2] = 4; gen_size[2] = 2; gen_pay[2] = 32'h2222;
    exp_seq = '{1, 1, 1, 1, 2};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("burst_grant", 64'(obs_grant), 64'(exp_seq[i]));
      if (i < 4) checkOutput("burst_ready2", 64'(obs_ready[2]), 64'(0));
    end

    $display("[TB] stalled downstream holds the pending master");
    clear_gens();
    applyStimulus(1'b0, 1'b1);
    gen_valid[3] = 1'b1; gen_op[3] = 4; gen_size[3] = 1; gen_pay[3] = 32'h3333;
    exp_seq = '{3, 3, 3, 3, 0};
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        gen_valid[0] = 1'b1; gen_op[0] = 4; gen_size[0] = 1; gen_pay[0] = 32'h4444;
      end
      applyStimulus(1'b1, (i >= 3));
      checkOutput("pend_grant", 64'(obs_grant), 64'(exp_seq[i]));
    end

    $display("[TB] reset in the middle of a burst");
    clear_gens();
    applyStimulus(1'b0, 1'b1);
    gen_valid[2] = 1'b1; gen_op[2] = 0; gen_size[2] = 5; gen_pay[2] = 32'h5555;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    gen_valid[1] = 1'b1; gen_op[1] = 4; gen_size[1] = 0; gen_pay[1] = 32'h6666;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("post_reset_grant", 64'(obs_grant), 64'(1));

    $display("[TB] burst stalled long enough to trip the watchdog");
    clear_gens();
    applyStimulus(1'b0, 1'b1);
    gen_valid[0] = 1'b1; gen_op[0] = 1; gen_size[0] = 5; gen_pay[0] = 32'h7777;
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < TO + 4; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("wd_sticky", 64'(timeout_o), 64'(WD_ON));

    $display("[TB] randomized traffic");
    clear_gens();
    applyStimulus(1'b0, 1'b1);
    raise_pct = 40;
    burst_pct = 80;
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < 70));
    end

    $display("test done: total=%0d bad=%0d", check_count, fail_count);
    $finish;
  end

endmodule
